mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/mc_opdecode.sv | 22 ++
 rtl/mc_control.sv | 152 +++++++++++++++
 tb/tb_mc_control.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states,
// opcode values, aluop codes, mux select values and opcode classes.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_src_a: 00 pc, 01 old pc, 10 register A
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_REG    = 2'b10;
  // alu_src_b: 00 register B, 01 immediate, 10 constant 4
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  // result_src: 00 ALU out register, 01 data register, 10 ALU result
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  typedef enum logic [2:0] {
    OPC_LOAD,
    OPC_STORE,
    OPC_RTYPE,
    OPC_ITYPE,
    OPC_BRANCH,
    OPC_JAL,
    OPC_ILLEGAL
  } opclass_t;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier for the multicycle controller.
module mc_opdecode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   opclass
);

  always_comb begin
    opclass = OPC_ILLEGAL;
    case (opcode)
      OP_LOAD:   opclass = OPC_LOAD;
      OP_STORE:  opclass = OPC_STORE;
      OP_RTYPE:  opclass = OPC_RTYPE;
      OP_ITYPE:  opclass = OPC_ITYPE;
      OP_BRANCH: opclass = OPC_BRANCH;
      OP_JAL:    opclass = OPC_JAL;
      default:   opclass = OPC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle RISC-V main control FSM. Optional memory wait states in
// FETCH/MEMREAD/MEMWRITE are enabled by defining MEM_WAIT_EN.
module mc_control
  import riscv_pkg::*;
#(
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic               adr_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [3:0]         state
);

  state_t   state_q, state_d;
  opclass_t opclass;
  logic     mem_ok;

  logic       pc_write_r, ir_write_r, mem_write_r, reg_write_r, adr_src_r, illegal_r;
  logic [1:0] alu_src_a_r, alu_src_b_r, result_src_r, aluop_r;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  mc_opdecode u_opdecode (
    .opcode  (opcode),
    .opclass (opclass)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_write_r   = 1'b0;
    ir_write_r   = 1'b0;
    mem_write_r  = 1'b0;
    reg_write_r  = 1'b0;
    adr_src_r    = 1'b0;
    illegal_r    = 1'b0;
    alu_src_a_r  = SRCA_PC;
    alu_src_b_r  = SRCB_REG;
    result_src_r = RES_ALUOUT;
    aluop_r      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_r   = mem_ok;
        pc_write_r   = mem_ok;
        alu_src_b_r  = SRCB_FOUR;
        result_src_r = RES_ALU;
        state_d      = mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_r = SRCA_OLDPC;
        alu_src_b_r = SRCB_IMM;
        case (opclass)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_RTYPE:           state_d = S_EXECUTER;
          OPC_ITYPE:           state_d = S_EXECUTEI;
          OPC_BRANCH:          state_d = S_BEQ;
          OPC_JAL:             state_d = S_JAL;
          default: begin
            illegal_r = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_r = SRCA_REG;
        alu_src_b_r = SRCB_IMM;
        state_d     = (opclass == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_r = 1'b1;
        state_d   = mem_ok ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        reg_write_r  = 1'b1;
        result_src_r = RES_DATA;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_r   = 1'b1;
        mem_write_r = mem_ok;
        state_d     = mem_ok ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a_r = SRCA_REG;
        alu_src_b_r = SRCB_REG;
        aluop_r     = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_r = SRCA_REG;
        alu_src_b_r = SRCB_IMM;
        aluop_r     = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_r = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_r = SRCA_REG;
        alu_src_b_r = SRCB_REG;
        aluop_r     = ALUOP_SUB;
        pc_write_r  = zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_r = SRCA_OLDPC;
        alu_src_b_r = SRCB_FOUR;
        pc_write_r  = 1'b1;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // The register may still hold a mid-instruction state while reset is low,
  // so every output is forced quiet until the first cycle out of reset.
  assign pc_write   = rst_n & pc_write_r;
  assign ir_write   = rst_n & ir_write_r;
  assign mem_write  = rst_n & mem_write_r;
  assign reg_write  = rst_n & reg_write_r;
  assign adr_src    = rst_n & adr_src_r;
  assign illegal    = rst_n & illegal_r;
  assign alu_src_a  = rst_n ? alu_src_a_r  : 2'b00;
  assign alu_src_b  = rst_n ? alu_src_b_r  : 2'b00;
  assign result_src = rst_n ? result_src_r : 2'b00;
  assign aluop      = rst_n ? ALUOP_W'(aluop_r) : '0;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control; covers the MEM_WAIT_EN
// build as well when that macro is defined.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, aluop;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7,
                         ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10;

  mc_control #(.ALUOP_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .aluop      (aluop),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    check("rst_state", state, FETCH);
    check("rst_pc_write", {3'b0, pc_write}, 4'd0);
    check("rst_ir_write", {3'b0, ir_write}, 4'd0);
    check("rst_illegal", {3'b0, illegal}, 4'd0);
    check("rst_srcb", {2'b0, alu_src_b}, 4'd0);

    // R-type
    rst_n = 1'b1; #1;
    check("r_fetch_ir", {3'b0, ir_write}, 4'd1);
    check("r_fetch_pc", {3'b0, pc_write}, 4'd1);
    check("r_fetch_srcb", {2'b0, alu_src_b}, 4'd2);
    check("r_fetch_res", {2'b0, result_src}, 4'd2);
    check("r_fetch_regw", {3'b0, reg_write}, 4'd0);
    tick();
    check("r_decode", state, DECODE);
    check("r_decode_srca", {2'b0, alu_src_a}, 4'd1);
    check("r_decode_srcb", {2'b0, alu_src_b}, 4'd1);
    check("r_decode_ill", {3'b0, illegal}, 4'd0);
    check("r_decode_regw", {3'b0, reg_write}, 4'd0);
    tick();
    check("r_exec", state, EXECUTER);
    check("r_exec_aluop", {2'b0, aluop}, 4'd2);
    check("r_exec_srca", {2'b0, alu_src_a}, 4'd2);
    check("r_exec_srcb", {2'b0, alu_src_b}, 4'd0);
    check("r_exec_regw", {3'b0, reg_write}, 4'd0);
    tick();
    check("r_aluwb", state, ALUWB);
    check("r_aluwb_regw", {3'b0, reg_write}, 4'd1);
    check("r_aluwb_res", {2'b0, result_src}, 4'd0);
    tick();
    check("r_back_fetch", state, FETCH);
    check("r_back_regw", {3'b0, reg_write}, 4'd0);

    // load: 5 cycles
    opcode = 7'b0000011;
    tick(); check("lw_decode", state, DECODE);
    tick(); check("lw_memadr", state, MEMADR);
    check("lw_memadr_srca", {2'b0, alu_src_a}, 4'd2);
    check("lw_memadr_srcb", {2'b0, alu_src_b}, 4'd1);
    tick(); check("lw_memread", state, MEMREAD);
    check("lw_memread_adr", {3'b0, adr_src}, 4'd1);
    check("lw_memread_regw", {3'b0, reg_write}, 4'd0);
    tick(); check("lw_memwb", state, MEMWB);
    check("lw_memwb_regw", {3'b0, reg_write}, 4'd1);
    check("lw_memwb_res", {2'b0, result_src}, 4'd1);
    tick(); check("lw_fetch", state, FETCH);

    // store: 4 cycles
    opcode = 7'b0100011;
    tick(); check("sw_decode", state, DECODE);
    tick(); check("sw_memadr", state, MEMADR);
    check("sw_memadr_memw", {3'b0, mem_write}, 4'd0);
    tick(); check("sw_memwrite", state, MEMWRITE);
    check("sw_memw", {3'b0, mem_write}, 4'd1);
    check("sw_adr", {3'b0, adr_src}, 4'd1);
    tick(); check("sw_fetch", state, FETCH);
    check("sw_fetch_memw", {3'b0, mem_write}, 4'd0);

    // beq: pc_write follows zero
    opcode = 7'b1100011; zero = 1'b1;
    tick(); check("beq_decode", state, DECODE);
    check("beq_decode_pcw", {3'b0, pc_write}, 4'd0);
    tick(); check("beq_state", state, BEQ);
    check("beq_z1_pcw", {3'b0, pc_write}, 4'd1);
    check("beq_z1_aluop", {2'b0, aluop}, 4'd1);
    zero = 1'b0; #1;
    check("beq_z0_pcw", {3'b0, pc_write}, 4'd0);
    check("beq_z0_aluop", {2'b0, aluop}, 4'd1);
    tick(); check("beq_fetch", state, FETCH);

    // jal
    opcode = 7'b1101111;
    tick(); check("jal_decode", state, DECODE);
    tick(); check("jal_state", state, JAL);
    check("jal_pcw", {3'b0, pc_write}, 4'd1);
    check("jal_srca", {2'b0, alu_src_a}, 4'd1);
    check("jal_srcb", {2'b0, alu_src_b}, 4'd2);
    tick(); check("jal_aluwb", state, ALUWB);
    check("jal_aluwb_regw", {3'b0, reg_write}, 4'd1);
    tick(); check("jal_fetch", state, FETCH);

    // illegal opcode
    opcode = 7'b1110011;
    tick(); check("ill_decode", state, DECODE);
    check("ill_pulse", {3'b0, illegal}, 4'd1);
    tick(); check("ill_fetch", state, FETCH);
    check("ill_cleared", {3'b0, illegal}, 4'd0);

    // I-type
    opcode = 7'b0010011;
    tick(); tick(); check("i_exec", state, EXECUTEI);
    check("i_srcb", {2'b0, alu_src_b}, 4'd1);
    check("i_aluop", {2'b0, aluop}, 4'd2);
    tick(); check("i_aluwb", state, ALUWB);
    tick(); check("i_fetch", state, FETCH);

    // reset during MEMADR of a store
    opcode = 7'b0100011;
    tick(); tick(); check("rs_memadr", state, MEMADR);
    rst_n = 1'b0; #1;
    check("rs_memw_low0", {3'b0, mem_write}, 4'd0);
    check("rs_adr_low0", {3'b0, adr_src}, 4'd0);
    tick(); check("rs_state", state, FETCH);
    check("rs_memw_low1", {3'b0, mem_write}, 4'd0);
    check("rs_ir_low", {3'b0, ir_write}, 4'd0);
    tick();
    rst_n = 1'b1; #1;
    check("rs_release_state", state, FETCH);
    check("rs_release_ir", {3'b0, ir_write}, 4'd1);
    check("rs_release_memw", {3'b0, mem_write}, 4'd0);

    // mem_ready handling in FETCH
    opcode = 7'b0110011; mem_ready = 1'b0; #1;
`ifdef MEM_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      check("mw_hold_state", state, FETCH);
      check("mw_hold_ir", {3'b0, ir_write}, 4'd0);
      check("mw_hold_pc", {3'b0, pc_write}, 4'd0);
      tick();
    end
    check("mw_still_fetch", state, FETCH);
    mem_ready = 1'b1; #1;
    check("mw_ready_ir", {3'b0, ir_write}, 4'd1);
    check("mw_ready_pc", {3'b0, pc_write}, 4'd1);
    tick(); check("mw_decode", state, DECODE);
`else
    check("nw_fetch_ir", {3'b0, ir_write}, 4'd1);
    tick(); check("nw_decode", state, DECODE);
    tick(); check("nw_exec", state, EXECUTER);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
